gold_seq_ctrl: RTL and testbench

Sequencing controller for a Gold-code generator pair built from two fill-loadable LFSR sub-blocks (A and B). It drives their shared shift enable, serially loads both seeds through the fill ports, and runs the generators at a chip-rate strobe. It also counts chips within a programmable code period, flags epochs, and optionally reloads the seeds at each epoch. It sits between the modem control registers and the generator sub-blocks.

---
 rtl/gold_seq_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_gold_seq_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gold_seq_ctrl.sv
// gold_seq_ctrl: sequencing controller for a Gold-code generator pair (LFSR A and B).
// Latency: Start -> first fill cycle 1 clk; fill lasts FILL_LEN clks; RUN chip outputs are same-cycle with Chip_Tick.
// Backpressure: none; Chip_Tick is a strobe, so ticks outside RUN (or coincident with Start/Stop) are dropped.
//
// Ports:
//   i_clock, i_reset_n            clock (rising edge), asynchronous active-low reset
//   i_start, i_stop               1-cycle control pulses (Stop wins over Start)
//   i_chip_tick                   chip-rate strobe
//   i_reload                      re-seed both generators at every epoch
//   i_code_len                    chips per period, 0 = free-run (no epoch)
//   i_seed_a, i_seed_b            seeds, latched on Start
//   o_gen_enable                  shift enable shared by both generators
//   o_fill_en_a/b, o_new_fill_a/b serial seed load, LSB first
//   o_chip_valid, o_chip_index    chip strobe and its index within the period
//   o_epoch                       pulse on the last chip of a period
//   o_busy                        controller is filling or running
module gold_seq_ctrl #(
  parameter int FILL_LEN = 26,
  parameter int CNT_W    = 16
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_chip_tick,
  input  logic                i_reload,
  input  logic [CNT_W-1:0]    i_code_len,
  input  logic [FILL_LEN-1:0] i_seed_a,
  input  logic [FILL_LEN-1:0] i_seed_b,
  output logic                o_gen_enable,
  output logic                o_fill_en_a,
  output logic                o_new_fill_a,
  output logic                o_fill_en_b,
  output logic                o_new_fill_b,
  output logic                o_chip_valid,
  output logic [CNT_W-1:0]    o_chip_index,
  output logic                o_epoch,
  output logic                o_busy
);

  localparam int FC_W = (FILL_LEN > 1) ? $clog2(FILL_LEN) : 1;
  localparam logic [FC_W-1:0]  FILL_LAST = FC_W'(FILL_LEN - 1);
  localparam logic [FC_W-1:0]  FC_ONE    = FC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t              r_state;
  logic [FILL_LEN-1:0] r_seed_a;      // seeds kept for epoch re-seeding
  logic [FILL_LEN-1:0] r_seed_b;
  logic [FILL_LEN-1:0] r_sh_a;        // fill shifters: bit 0 is the bit presented this fill cycle
  logic [FILL_LEN-1:0] r_sh_b;
  logic [CNT_W-1:0]    r_code_len;
  logic [CNT_W-1:0]    r_chip_index;
  logic [FC_W-1:0]     r_fill_cnt;
  logic                r_fill_en;     // registered copies of the state decode
  logic                r_run;
  logic                r_busy;

  logic w_tick_ok;
  logic w_last_chip;

  // A tick only becomes a chip in RUN, and not when the same cycle carries a
  // restart or abort: that tick would belong to a sequence being discarded.
  assign w_tick_ok   = r_run & i_chip_tick & ~i_start & ~i_stop;

  // Code length 0 means free-run: the index wraps naturally and no epoch fires.
  assign w_last_chip = (r_code_len != '0) && (r_chip_index == (r_code_len - CNT_ONE));

  assign o_gen_enable = r_fill_en | w_tick_ok;
  assign o_fill_en_a  = r_fill_en;
  assign o_fill_en_b  = r_fill_en;
  assign o_new_fill_a = r_fill_en & r_sh_a[0];
  assign o_new_fill_b = r_fill_en & r_sh_b[0];
  assign o_chip_valid = w_tick_ok;
  assign o_chip_index = r_chip_index;
  assign o_epoch      = w_tick_ok & w_last_chip;
  assign o_busy       = r_busy;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_seed_a     <= '0;
      r_seed_b     <= '0;
      r_sh_a       <= '0;
      r_sh_b       <= '0;
      r_code_len   <= '0;
      r_chip_index <= '0;
      r_fill_cnt   <= '0;
      r_fill_en    <= 1'b0;
      r_run        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_stop) begin
            r_state      <= S_FILL;
            r_seed_a     <= i_seed_a;
            r_seed_b     <= i_seed_b;
            r_sh_a       <= i_seed_a;
            r_sh_b       <= i_seed_b;
            r_code_len   <= i_code_len;
            r_chip_index <= '0;
            r_fill_cnt   <= '0;
            r_fill_en    <= 1'b1;
            r_run        <= 1'b0;
            r_busy       <= 1'b1;
          end
        end

        S_FILL: begin
          if (i_stop) begin
            r_state   <= S_IDLE;
            r_fill_en <= 1'b0;
            r_run     <= 1'b0;
            r_busy    <= 1'b0;
          end else begin
            // Start is ignored here; the fill always completes once begun.
            r_sh_a <= {1'b0, r_sh_a[FILL_LEN-1:1]};
            r_sh_b <= {1'b0, r_sh_b[FILL_LEN-1:1]};
            if (r_fill_cnt == FILL_LAST) begin
              r_state    <= S_RUN;
              r_fill_cnt <= '0;
              r_fill_en  <= 1'b0;
              r_run      <= 1'b1;
            end else begin
              r_fill_cnt <= r_fill_cnt + FC_ONE;
            end
          end
        end

        S_RUN: begin
          if (i_stop) begin
            // Chip index is left frozen for software to inspect.
            r_state   <= S_IDLE;
            r_fill_en <= 1'b0;
            r_run     <= 1'b0;
            r_busy    <= 1'b0;
          end else if (i_start) begin
            r_state      <= S_FILL;
            r_seed_a     <= i_seed_a;
            r_seed_b     <= i_seed_b;
            r_sh_a       <= i_seed_a;
            r_sh_b       <= i_seed_b;
            r_code_len   <= i_code_len;
            r_chip_index <= '0;
            r_fill_cnt   <= '0;
            r_fill_en    <= 1'b1;
            r_run        <= 1'b0;
          end else if (w_tick_ok) begin
            if (w_last_chip) begin
              r_chip_index <= '0;
              if (i_reload) begin
                // Re-seed from the latched seeds so the next period repeats this one.
                r_state    <= S_FILL;
                r_sh_a     <= r_seed_a;
                r_sh_b     <= r_seed_b;
                r_fill_cnt <= '0;
                r_fill_en  <= 1'b1;
                r_run      <= 1'b0;
              end
            end else begin
              r_chip_index <= r_chip_index + CNT_ONE;
            end
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_fill_en <= 1'b0;
          r_run     <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gold_seq_ctrl.sv
// tb_gold_seq_ctrl: scoreboard bench for gold_seq_ctrl.
// Stimulus pushes the expected output record for every cycle that should show activity;
// a negedge monitor pops and compares whenever any enable/strobe output is high.
`timescale 1ns/1ps
module tb_gold_seq_ctrl;
  localparam int FL = 26;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          chip_tick = 1'b0;
  logic          reload = 1'b0;
  logic [CW-1:0] code_len = '0;
  logic [FL-1:0] seed_a = '0;
  logic [FL-1:0] seed_b = '0;

  logic          o_gen_enable, o_fill_en_a, o_new_fill_a, o_fill_en_b, o_new_fill_b;
  logic          o_chip_valid, o_epoch, o_busy;
  logic [CW-1:0] o_chip_index;

  always #5 clk = ~clk;

  gold_seq_ctrl #(.FILL_LEN(FL), .CNT_W(CW)) dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_start      (start),
    .i_stop       (stop),
    .i_chip_tick  (chip_tick),
    .i_reload     (reload),
    .i_code_len   (code_len),
    .i_seed_a     (seed_a),
    .i_seed_b     (seed_b),
    .o_gen_enable (o_gen_enable),
    .o_fill_en_a  (o_fill_en_a),
    .o_new_fill_a (o_new_fill_a),
    .o_fill_en_b  (o_fill_en_b),
    .o_new_fill_b (o_new_fill_b),
    .o_chip_valid (o_chip_valid),
    .o_chip_index (o_chip_index),
    .o_epoch      (o_epoch),
    .o_busy       (o_busy)
  );

  typedef struct packed {
    logic          ge;
    logic          fa;
    logic          nfa;
    logic          fb;
    logic          nfb;
    logic          cv;
    logic          ep;
    logic [CW-1:0] idx;
  } rec_t;

  rec_t q_exp[$];
  logic q_chip[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference generator A: a plain delay line loaded by the fill port and
  // recirculated on run shifts; its bit 0 is the chip the generator presents.
  logic [FL-1:0] gm = '0;
  always @(posedge clk)
    if (o_gen_enable)
      gm <= o_fill_en_a ? {o_new_fill_a, gm[FL-1:1]} : {gm[0], gm[FL-1:1]};

  logic [CW+8:0] all_outs;
  assign all_outs = {o_busy, o_gen_enable, o_fill_en_a, o_new_fill_a, o_fill_en_b,
                     o_new_fill_b, o_chip_valid, o_epoch, 1'b0, o_chip_index};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic rec_t fill_rec(input logic a, input logic b);
    rec_t r;
    r = '{ge:1'b1, fa:1'b1, nfa:a, fb:1'b1, nfb:b, cv:1'b0, ep:1'b0, idx:'0};
    return r;
  endfunction

  function automatic rec_t chip_rec(input logic [CW-1:0] idx, input logic ep);
    rec_t r;
    r = '{ge:1'b1, fa:1'b0, nfa:1'b0, fb:1'b0, nfb:1'b0, cv:1'b1, ep:ep, idx:idx};
    return r;
  endfunction

  // Monitor: every cycle with visible activity must match the next expected record.
  always @(negedge clk) begin
    rec_t act;
    rec_t exp;
    if (o_gen_enable | o_fill_en_a | o_fill_en_b | o_new_fill_a | o_new_fill_b |
        o_chip_valid | o_epoch) begin
      act = {o_gen_enable, o_fill_en_a, o_new_fill_a, o_fill_en_b, o_new_fill_b,
             o_chip_valid, o_epoch, o_chip_index};
      if (q_exp.size() == 0) begin
        chk("unexpected_output", 64'(act), 64'd0);
      end else begin
        exp = q_exp.pop_front();
        chk("out_seq", 64'(act), 64'(exp));
      end
      if (o_chip_valid) q_chip.push_back(gm[0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fill cycles; optionally toggle Chip_Tick to show it is ignored.
  task automatic fill_seq(input logic [FL-1:0] a, input logic [FL-1:0] b, input bit ticks);
    for (int k = 0; k < FL; k++) begin
      chip_tick = ticks & (k % 2 == 1);
      q_exp.push_back(fill_rec(a[k], b[k]));
      step();
    end
    chip_tick = 1'b0;
  endtask

  task automatic begin_fill(input logic [FL-1:0] a, input logic [FL-1:0] b,
                            input logic [CW-1:0] len, input bit ticks);
    seed_a = a; seed_b = b; code_len = len;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_in_fill", 64'(o_busy), 64'd1);
    fill_seq(a, b, ticks);
  endtask

  // gap idle clocks, then one tick cycle carrying the given chip.
  task automatic chip(input logic [CW-1:0] idx, input logic ep, input int gap);
    repeat (gap) step();
    chip_tick = 1'b1;
    q_exp.push_back(chip_rec(idx, ep));
    step();
    chip_tick = 1'b0;
  endtask

  initial begin
    logic [FL-1:0] sa;
    // Reset
    repeat (3) step();
    chk("reset_outputs", 64'(all_outs), 64'd0);
    rst_n = 1'b1;
    chip_tick = 1'b1;
    repeat (2) step();
    chip_tick = 1'b0;
    chk("idle_after_reset_busy", 64'(o_busy), 64'd0);

    // Fill with single-bit seeds, then ticks every 4th clock, Code_Len=5
    begin_fill(26'h0000001, 26'h2000000, 16'd5, 1'b1);
    for (int i = 0; i < 6; i++) chip(16'(i % 5), (i == 4), 3);
    chk("chip_count_p5", 64'(q_chip.size()), 64'd6);
    chk("first_chip_a", 64'(q_chip[0]), 64'd1);
    chk("busy_in_run", 64'(o_busy), 64'd1);

    // Start+Stop together in RUN: Stop wins, index frozen at 1
    seed_a = 26'h1234567; seed_b = 26'h0765432; code_len = 16'd9;
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", 64'(o_busy), 64'd0);
    chk("startstop_gen_en", 64'(o_gen_enable), 64'd0);
    chk("startstop_index", 64'(o_chip_index), 64'd1);
    chip_tick = 1'b1;
    repeat (3) step();
    chip_tick = 1'b0;
    chk("startstop_still_idle", 64'(o_busy), 64'd0);

    // Reload at every epoch, Code_Len=3
    q_chip.delete();
    sa = 26'h0000005;
    begin_fill(sa, 26'h2AAAAAA, 16'd3, 1'b1);
    chip(16'd0, 1'b0, 1);
    chip(16'd1, 1'b0, 1);
    reload = 1'b1;
    chip(16'd2, 1'b1, 1);
    reload = 1'b0;
    for (int k = 0; k < FL; k++) begin
      chip_tick = 1'b1;  // every refill tick must be dropped
      q_exp.push_back(fill_rec(sa[k], FL'(26'h2AAAAAA) >> k));
      step();
    end
    chip_tick = 1'b0;
    chip(16'd0, 1'b0, 1);
    chip(16'd1, 1'b0, 1);
    chip(16'd2, 1'b1, 1);
    chip(16'd0, 1'b0, 1);
    chk("chip_count_reload", 64'(q_chip.size()), 64'd7);
    for (int i = 0; i < 3; i++) begin
      chk("period1_chip", 64'(q_chip[i]), 64'(sa[i]));
      chk("period2_repeat", 64'(q_chip[i+3]), 64'(sa[i]));
    end
    chk("no_reload_stays_run", 64'(o_busy), 64'd1);

    // Stop during fill cycle 10
    seed_a = 26'h0000003; seed_b = 26'h0000001; code_len = 16'd5;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      q_exp.push_back(fill_rec(seed_a[k], seed_b[k]));
      if (k == 10) stop = 1'b1;
      step();
    end
    stop = 1'b0;
    chk("stopfill_busy", 64'(o_busy), 64'd0);
    chk("stopfill_gen_en", 64'(o_gen_enable), 64'd0);
    chk("stopfill_fill_en", 64'(o_fill_en_a), 64'd0);
    chk("stopfill_index", 64'(o_chip_index), 64'd0);
    chip_tick = 1'b1;
    repeat (2) step();
    chip_tick = 1'b0;

    // Asynchronous reset mid-RUN
    begin_fill(26'h0000155, 26'h00000AA, 16'd5, 1'b0);
    chip(16'd0, 1'b0, 2);
    chip(16'd1, 1'b0, 2);
    #1 rst_n = 1'b0;
    #1 chk("async_reset_outputs", 64'(all_outs), 64'd0);
    chip_tick = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    chip_tick = 1'b0;
    chk("post_reset_idle_busy", 64'(o_busy), 64'd0);
    chk("post_reset_index", 64'(o_chip_index), 64'd0);

    // Free-run (Code_Len=0): index wraps at 2^16, no epoch
    begin_fill(26'h3FFFFFF, 26'h0F0F0F0, 16'd0, 1'b0);
    for (int i = 0; i < 70000; i++) begin
      chip_tick = 1'b1;
      q_exp.push_back(chip_rec(i[15:0], 1'b0));
      step();
    end
    chip_tick = 1'b0;
    chk("freerun_final_index", 64'(o_chip_index), 64'd4464);

    // Restart from RUN with a coincident tick, then Code_Len=1
    seed_a = 26'h0000002; seed_b = 26'h0000004; code_len = 16'd1;
    start = 1'b1; chip_tick = 1'b1;
    step();
    start = 1'b0; chip_tick = 1'b0;
    chk("restart_busy", 64'(o_busy), 64'd1);
    fill_seq(26'h0000002, 26'h0000004, 1'b0);
    for (int i = 0; i < 4; i++) chip(16'd0, 1'b1, 1);

    stop = 1'b1; step(); stop = 1'b0;
    chk("final_stop_busy", 64'(o_busy), 64'd0);
    repeat (3) step();
    chk("queue_drained", 64'(q_exp.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
